// File: rtl/alu_pkg.sv
// Shared ALU definitions: op vector width, one-hot op bit positions and a legality helper.
package alu_pkg;

    localparam int ALU_OP_W = 12;
    localparam int DATA_W   = 32;

    localparam int ALU_OP_ADD  = 0;
    localparam int ALU_OP_SUB  = 1;
    localparam int ALU_OP_SLT  = 2;
    localparam int ALU_OP_SLTU = 3;
    localparam int ALU_OP_AND  = 4;
    localparam int ALU_OP_NOR  = 5;
    localparam int ALU_OP_OR   = 6;
    localparam int ALU_OP_XOR  = 7;
    localparam int ALU_OP_SLL  = 8;
    localparam int ALU_OP_SRL  = 9;
    localparam int ALU_OP_SRA  = 10;
    localparam int ALU_OP_LUI  = 11;

    // An op is legal only when exactly one bit is set.
    function automatic logic is_onehot(input logic [ALU_OP_W-1:0] op);
        return (op != '0) && ((op & (op - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/alu.sv
// Shared combinational 32-bit ALU driven by a one-hot op vector.
module alu
    import alu_pkg::*;
(
    input  logic [ALU_OP_W-1:0] op,
    input  logic [DATA_W-1:0]   src1,
    input  logic [DATA_W-1:0]   src2,
    output logic [DATA_W-1:0]   result
);

    logic signed [DATA_W-1:0] s1;
    logic signed [DATA_W-1:0] s2;
    logic        [4:0]        shamt;

    assign s1    = src1;
    assign s2    = src2;
    assign shamt = src2[4:0];

    // OR together the per-op results gated by their op bit; a zero op yields zero.
    always_comb begin
        result = '0;
        if (op[ALU_OP_ADD])  result = result | (src1 + src2);
        if (op[ALU_OP_SUB])  result = result | (src1 - src2);
        if (op[ALU_OP_SLT])  result = result | {{(DATA_W-1){1'b0}}, (s1 < s2)};
        if (op[ALU_OP_SLTU]) result = result | {{(DATA_W-1){1'b0}}, (src1 < src2)};
        if (op[ALU_OP_AND])  result = result | (src1 & src2);
        if (op[ALU_OP_NOR])  result = result | ~(src1 | src2);
        if (op[ALU_OP_OR])   result = result | (src1 | src2);
        if (op[ALU_OP_XOR])  result = result | (src1 ^ src2);
        if (op[ALU_OP_SLL])  result = result | (src1 << shamt);
        if (op[ALU_OP_SRL])  result = result | (src1 >> shamt);
        if (op[ALU_OP_SRA])  result = result | DATA_W'(s1 >>> shamt);
        if (op[ALU_OP_LUI])  result = result | src2;
    end

endmodule

// File: rtl/alu_rr_arb2.sv
// Two-way round-robin grant: a port is granted when its response slot can take a result
// and either the other port is not competing or the pointer favours it.
module alu_rr_arb2 (
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] req_valid,
    input  logic [1:0] elig,
    output logic [1:0] grant
);

    logic       prio;
    logic [1:0] cand;
    logic [1:0] hs;

    assign cand = req_valid & elig;
    assign hs   = req_valid & grant;

    // Grant ignores the port's own valid so ready never combinationally loops on it.
    always_comb begin
        grant    = '0;
        grant[0] = resetn & elig[0] & (~cand[1] | ~prio);
        grant[1] = resetn & elig[1] & (~cand[0] |  prio);
    end

    // Pointer moves to the port that did not just win; holds when idle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)    prio <= 1'b0;
        else if (hs[0]) prio <= 1'b1;
        else if (hs[1]) prio <= 1'b0;
    end

endmodule

// File: rtl/alu_share_arb.sv
// Two-requester front end for one shared ALU: round-robin arbitration, zero-gated ALU drive,
// and a 1-entry response buffer per port carrying result, tag and illegal-op flag.
module alu_share_arb
    import alu_pkg::*;
#(
    parameter int TAG_W = 4,
    parameter int NPORT = 2
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [ALU_OP_W-1:0] req_op0,
    input  logic [DATA_W-1:0]   req_src1_0,
    input  logic [DATA_W-1:0]   req_src2_0,
    input  logic [TAG_W-1:0]    req_tag0,
    input  logic [ALU_OP_W-1:0] req_op1,
    input  logic [DATA_W-1:0]   req_src1_1,
    input  logic [DATA_W-1:0]   req_src2_1,
    input  logic [TAG_W-1:0]    req_tag1,
    output logic [1:0]          rsp_valid,
    input  logic [1:0]          rsp_ready,
    output logic [DATA_W-1:0]   rsp_result0,
    output logic [TAG_W-1:0]    rsp_tag0,
    output logic                rsp_err0,
    output logic [DATA_W-1:0]   rsp_result1,
    output logic [TAG_W-1:0]    rsp_tag1,
    output logic                rsp_err1
);

    if (NPORT != 2) begin : g_bad_nport
        $error("alu_share_arb supports exactly two requesters");
    end

    logic [1:0]          elig;
    logic [1:0]          hs;
    logic [ALU_OP_W-1:0] alu_op;
    logic [DATA_W-1:0]   alu_src1;
    logic [DATA_W-1:0]   alu_src2;
    logic [DATA_W-1:0]   alu_result;
    logic [TAG_W-1:0]    alu_tag;
    logic                illegal;

    logic [1:0]          vld_p1;
    logic [DATA_W-1:0]   result_p1 [2];
    logic [TAG_W-1:0]    tag_p1    [2];
    logic [1:0]          err_p1;

    // A slot accepts a new result when empty or being drained this cycle.
    assign elig = ~vld_p1 | rsp_ready;
    assign hs   = req_valid & req_ready;

    alu_rr_arb2 u_arb (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .elig      (elig),
        .grant     (req_ready)
    );

    // Steer the winner onto the ALU; hold all ALU inputs at zero when nothing is accepted.
    always_comb begin
        alu_op   = '0;
        alu_src1 = '0;
        alu_src2 = '0;
        alu_tag  = '0;
        if (hs[0]) begin
            alu_op   = req_op0;
            alu_src1 = req_src1_0;
            alu_src2 = req_src2_0;
            alu_tag  = req_tag0;
        end else if (hs[1]) begin
            alu_op   = req_op1;
            alu_src1 = req_src1_1;
            alu_src2 = req_src2_1;
            alu_tag  = req_tag1;
        end
    end

    assign illegal = ~is_onehot(alu_op);

    alu u_alu (
        .op     (alu_op),
        .src1   (alu_src1),
        .src2   (alu_src2),
        .result (alu_result)
    );

    // Response buffers: capture on handshake, clear valid on drain, otherwise hold payload.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_p1 <= '0;
            err_p1 <= '0;
            for (int i = 0; i < 2; i++) begin
                result_p1[i] <= '0;
                tag_p1[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (hs[i]) begin
                    vld_p1[i]    <= 1'b1;
                    result_p1[i] <= illegal ? '0 : alu_result;
                    tag_p1[i]    <= alu_tag;
                    err_p1[i]    <= illegal;
                end else if (rsp_ready[i]) begin
                    vld_p1[i]    <= 1'b0;
                end
            end
        end
    end

    assign rsp_valid   = vld_p1;
    assign rsp_result0 = result_p1[0];
    assign rsp_tag0    = tag_p1[0];
    assign rsp_err0    = err_p1[0];
    assign rsp_result1 = result_p1[1];
    assign rsp_tag1    = tag_p1[1];
    assign rsp_err1    = err_p1[1];

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: directed scenarios plus randomized traffic against a behavioural model.
module tb_alu_share_arb;

    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             resetn;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [11:0]      req_op0, req_op1;
    logic [31:0]      req_src1_0, req_src2_0, req_src1_1, req_src2_1;
    logic [TAG_W-1:0] req_tag0, req_tag1;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [31:0]      rsp_result0, rsp_result1;
    logic [TAG_W-1:0] rsp_tag0, rsp_tag1;
    logic             rsp_err0, rsp_err1;

    always #5 clk = ~clk;

    alu_share_arb #(.TAG_W(TAG_W), .NPORT(2)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op0(req_op0), .req_src1_0(req_src1_0), .req_src2_0(req_src2_0), .req_tag0(req_tag0),
        .req_op1(req_op1), .req_src1_1(req_src1_1), .req_src2_1(req_src2_1), .req_tag1(req_tag1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result0(rsp_result0), .rsp_tag0(rsp_tag0), .rsp_err0(rsp_err0),
        .rsp_result1(rsp_result1), .rsp_tag1(rsp_tag1), .rsp_err1(rsp_err1)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model state: what each response slot should hold and who has priority.
    logic [1:0]       m_vld;
    logic [31:0]      m_res [2];
    logic [TAG_W-1:0] m_tag [2];
    logic             m_err [2];
    int               m_prio;

    // Reference ALU: {err, result}.
    function automatic logic [32:0] ref_alu(input logic [11:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        int sh;
        sh = int'(b[4:0]);
        if ($countones(op) != 1) return {1'b1, 32'h0};
        if (op[0])       r = a + b;
        else if (op[1])  r = a - b;
        else if (op[2])  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        else if (op[3])  r = (a < b) ? 32'd1 : 32'd0;
        else if (op[4])  r = a & b;
        else if (op[5])  r = ~(a | b);
        else if (op[6])  r = a | b;
        else if (op[7])  r = a ^ b;
        else if (op[8])  r = a << sh;
        else if (op[9])  r = a >> sh;
        else if (op[10]) r = 32'($signed(a) >>> sh);
        else             r = b;
        return {1'b0, r};
    endfunction

    // Which port the model expects to be accepted this cycle (-1 for none).
    function automatic int winner();
        bit c0, c1;
        c0 = req_valid[0] && (!m_vld[0] || rsp_ready[0]);
        c1 = req_valid[1] && (!m_vld[1] || rsp_ready[1]);
        if (c0 && c1) return m_prio;
        if (c0) return 0;
        if (c1) return 1;
        return -1;
    endfunction

    function automatic logic [1:0] onehot_of(input int w);
        return (w < 0) ? 2'b00 : ((w == 0) ? 2'b01 : 2'b10);
    endfunction

    task automatic model_reset();
        m_vld  = 2'b00;
        m_prio = 0;
        for (int i = 0; i < 2; i++) begin
            m_res[i] = '0;
            m_tag[i] = '0;
            m_err[i] = 1'b0;
        end
    endtask

    task automatic set_port(input int p, input bit v, input logic [11:0] op,
                            input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] tag);
        req_valid[p] = v;
        if (p == 0) begin
            req_op0 = op; req_src1_0 = a; req_src2_0 = b; req_tag0 = tag;
        end else begin
            req_op1 = op; req_src1_1 = a; req_src2_1 = b; req_tag1 = tag;
        end
    endtask

    // Advance one clock from a falling edge to the next, updating the model across the rising edge.
    task automatic tick();
        int w;
        logic [32:0] r;
        w = winner();
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (w == i) begin
                r = (i == 0) ? ref_alu(req_op0, req_src1_0, req_src2_0)
                             : ref_alu(req_op1, req_src1_1, req_src2_1);
                m_vld[i] = 1'b1;
                m_res[i] = r[31:0];
                m_err[i] = r[32];
                m_tag[i] = (i == 0) ? req_tag0 : req_tag1;
            end else if (m_vld[i] && rsp_ready[i]) begin
                m_vld[i] = 1'b0;
            end
        end
        if (w >= 0) m_prio = 1 - w;
        @(negedge clk);
    endtask

    task automatic test_reset();
        resetn    = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        set_port(0, 1'b1, 12'h001, 32'd1, 32'd2, 4'd1);
        set_port(1, 1'b1, 12'h001, 32'd3, 32'd4, 4'd2);
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got %b want 00", rsp_valid); end
        checks++;
        if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got %b want 00", req_ready); end
        checks++;
        if ({rsp_result0, rsp_result1, rsp_tag0, rsp_tag1, rsp_err0, rsp_err1} !== '0) begin
            errors++;
            $display("FAIL reset_payload got %h %h %h %h %b %b want all zero",
                     rsp_result0, rsp_result1, rsp_tag0, rsp_tag1, rsp_err0, rsp_err1);
        end
        resetn = 1'b1;
        #1;
        checks++;
        if ((req_ready & req_valid) !== 2'b01) begin
            errors++; $display("FAIL reset_first_tie got %b want 01", req_ready & req_valid);
        end
        req_valid = 2'b00;
    endtask

    task automatic test_single();
        rsp_ready = 2'b11;
        set_port(0, 1'b1, 12'h001, 32'h5, 32'h3, 4'd3);
        set_port(1, 1'b0, 12'h000, 32'h0, 32'h0, 4'd0);
        #1;
        checks++;
        if (req_ready[0] !== 1'b1) begin errors++; $display("FAIL single_ready got %b want 1", req_ready[0]); end
        tick();
        req_valid = 2'b00;
        checks++;
        if (rsp_valid !== 2'b01) begin errors++; $display("FAIL single_valid got %b want 01", rsp_valid); end
        checks++;
        if ({rsp_result0, rsp_tag0, rsp_err0} !== {32'h8, 4'd3, 1'b0}) begin
            errors++; $display("FAIL single_rsp got %h/%0d/%b want 00000008/3/0", rsp_result0, rsp_tag0, rsp_err0);
        end
    endtask

    task automatic test_alternate();
        int w;
        logic [1:0] prev;
        bit done;
        rsp_ready = 2'b11;
        set_port(0, 1'b1, 12'h002, 32'd3, 32'd5, 4'd4);
        set_port(1, 1'b1, 12'h004, 32'hFFFF_FFFF, 32'd1, 4'd5);
        prev = 2'b00;
        for (int k = 0; k < 4; k++) begin
            #1;
            w = winner();
            checks++;
            if ((req_ready & req_valid) !== onehot_of(w)) begin
                errors++; $display("FAIL alt_grant cyc %0d got %b want %b", k, req_ready & req_valid, onehot_of(w));
            end
            checks++;
            if (k > 0 && (req_ready & req_valid) === prev) begin
                errors++; $display("FAIL alt_repeat cyc %0d got %b want not %b", k, req_ready & req_valid, prev);
            end
            prev = req_ready & req_valid;
            tick();
            checks++;
            if (w == 0 && rsp_result0 !== 32'hFFFF_FFFE) begin
                errors++; $display("FAIL alt_sub got %h want fffffffe", rsp_result0);
            end else if (w == 1 && rsp_result1 !== 32'h1) begin
                errors++; $display("FAIL alt_slt got %h want 00000001", rsp_result1);
            end
        end
        req_op1 = 12'h008;
        done = 1'b0;
        for (int k = 0; k < 3 && !done; k++) begin
            w = winner();
            tick();
            if (w == 1) begin
                done = 1'b1;
                checks++;
                if (rsp_result1 !== 32'h0) begin errors++; $display("FAIL alt_sltu got %h want 00000000", rsp_result1); end
            end
        end
        if (!done) begin checks++; errors++; $display("FAIL alt_sltu_timeout got none want grant"); end
        req_valid = 2'b00;
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        rsp_ready = 2'b01;
        set_port(0, 1'b1, 12'h001, $urandom, $urandom, 4'd6);
        set_port(1, 1'b1, 12'h080, $urandom, $urandom, 4'd7);
        for (int k = 0; k < 3 && !m_vld[1]; k++) tick();
        checks++;
        if (rsp_valid[1] !== 1'b1) begin errors++; $display("FAIL bp_fill got %b want 1", rsp_valid[1]); end
        held = m_res[1];
        for (int k = 0; k < 4; k++) begin
            set_port(0, 1'b1, 12'h001, $urandom, $urandom, 4'(k));
            set_port(1, 1'b1, 12'h080, $urandom, $urandom, 4'(k + 8));
            #1;
            checks++;
            if (req_ready !== 2'b01) begin errors++; $display("FAIL bp_ready cyc %0d got %b want 01", k, req_ready); end
            tick();
            checks++;
            if ({rsp_valid, rsp_result1, rsp_result0} !== {2'b11, held, m_res[0]}) begin
                errors++; $display("FAIL bp_hold cyc %0d got %b %h %h want 11 %h %h",
                                   k, rsp_valid, rsp_result1, rsp_result0, held, m_res[0]);
            end
        end
        set_port(1, 1'b1, 12'h080, 32'h1234_5678, 32'h0F0F_0F0F, 4'd9);
        rsp_ready = 2'b11;
        #1;
        checks++;
        if (req_ready[1] !== 1'b1) begin errors++; $display("FAIL bp_refill_ready got %b want 1", req_ready[1]); end
        tick();
        checks++;
        if ({rsp_valid[1], rsp_result1, rsp_tag1} !== {1'b1, 32'h1D3B_5977, 4'd9}) begin
            errors++; $display("FAIL bp_refill got %b %h %0d want 1 1d3b5977 9", rsp_valid[1], rsp_result1, rsp_tag1);
        end
        req_valid = 2'b00;
    endtask

    task automatic test_illegal();
        rsp_ready = 2'b11;
        set_port(1, 1'b0, 12'h001, 32'd0, 32'd0, 4'd0);
        set_port(0, 1'b1, 12'h000, 32'h11, 32'h22, 4'd1);
        tick();
        checks++;
        if ({rsp_err0, rsp_result0} !== {1'b1, 32'h0}) begin
            errors++; $display("FAIL illegal_zero got %b %h want 1 00000000", rsp_err0, rsp_result0);
        end
        set_port(0, 1'b1, 12'h003, 32'h1, 32'h1, 4'd2);
        tick();
        checks++;
        if ({rsp_err0, rsp_result0, rsp_tag0} !== {1'b1, 32'h0, 4'd2}) begin
            errors++; $display("FAIL illegal_multi got %b %h %0d want 1 00000000 2", rsp_err0, rsp_result0, rsp_tag0);
        end
        set_port(0, 1'b1, 12'h001, 32'h1, 32'h1, 4'd3);
        set_port(1, 1'b1, 12'h001, 32'h2, 32'h2, 4'd4);
        #1;
        checks++;
        if ((req_ready & req_valid) !== 2'b10) begin
            errors++; $display("FAIL illegal_ptr got %b want 10", req_ready & req_valid);
        end
        tick();
        req_valid = 2'b00;
    endtask

    task automatic test_shifts();
        rsp_ready = 2'b11;
        set_port(0, 1'b0, 12'h001, 32'd0, 32'd0, 4'd0);
        set_port(1, 1'b1, 12'h400, 32'h8000_0000, 32'd4, 4'd10);
        tick();
        checks++;
        if ({rsp_result1, rsp_tag1, rsp_err1} !== {32'hF800_0000, 4'd10, 1'b0}) begin
            errors++; $display("FAIL sra got %h %0d %b want f8000000 10 0", rsp_result1, rsp_tag1, rsp_err1);
        end
        set_port(1, 1'b1, 12'h200, 32'h8000_0000, 32'd4, 4'd11);
        tick();
        checks++;
        if (rsp_result1 !== 32'h0800_0000) begin errors++; $display("FAIL srl got %h want 08000000", rsp_result1); end
        set_port(1, 1'b1, 12'h800, $urandom, 32'hABCD_E000, 4'd12);
        tick();
        checks++;
        if (rsp_result1 !== 32'hABCD_E000) begin errors++; $display("FAIL lui got %h want abcde000", rsp_result1); end
        req_valid = 2'b00;
    endtask

    task automatic test_random();
        int w;
        logic [11:0] op;
        for (int k = 0; k < 400; k++) begin
            for (int p = 0; p < 2; p++) begin
                op = ($urandom_range(0, 7) == 0) ? 12'($urandom) : (12'h001 << $urandom_range(0, 11));
                set_port(p, 1'($urandom), op, $urandom, $urandom, 4'($urandom));
            end
            rsp_ready = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
            #1;
            w = winner();
            checks++;
            if ((req_ready & req_valid) !== onehot_of(w)) begin
                errors++; $display("FAIL rand_grant cyc %0d got %b want %b", k, req_ready & req_valid, onehot_of(w));
            end
            tick();
            checks++;
            if ({rsp_valid, rsp_result0, rsp_tag0, rsp_err0, rsp_result1, rsp_tag1, rsp_err1} !==
                {m_vld, m_res[0], m_tag[0], m_err[0], m_res[1], m_tag[1], m_err[1]}) begin
                errors++;
                $display("FAIL rand_rsp cyc %0d got %b %h %h %b %h %h %b want %b %h %h %b %h %h %b", k,
                         rsp_valid, rsp_result0, rsp_tag0, rsp_err0, rsp_result1, rsp_tag1, rsp_err1,
                         m_vld, m_res[0], m_tag[0], m_err[0], m_res[1], m_tag[1], m_err[1]);
            end
        end
        req_valid = 2'b00;
    endtask

    task automatic test_reset_midflight();
        rsp_ready = 2'b00;
        set_port(0, 1'b1, 12'h001, 32'd7, 32'd8, 4'd1);
        set_port(1, 1'b1, 12'h001, 32'd9, 32'd10, 4'd2);
        tick();
        tick();
        checks++;
        if (rsp_valid !== 2'b11) begin errors++; $display("FAIL mid_full got %b want 11", rsp_valid); end
        resetn = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({rsp_valid, req_ready} !== 4'b0000) begin
            errors++; $display("FAIL mid_reset got %b %b want 00 00", rsp_valid, req_ready);
        end
        @(negedge clk);
        resetn    = 1'b1;
        rsp_ready = 2'b11;
        #1;
        checks++;
        if ((req_ready & req_valid) !== 2'b01) begin
            errors++; $display("FAIL mid_tie got %b want 01", req_ready & req_valid);
        end
        tick();
        checks++;
        if ({rsp_valid, rsp_result0, rsp_tag0} !== {2'b01, 32'd15, 4'd1}) begin
            errors++; $display("FAIL mid_after got %b %h %0d want 01 0000000f 1", rsp_valid, rsp_result0, rsp_tag0);
        end
        req_valid = 2'b00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        @(negedge clk);
        test_single();
        test_alternate();
        test_backpressure();
        test_illegal();
        test_shifts();
        test_random();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
Shares one combinational 32-bit ALU (`alu`, 12-bit one-hot `alu_op`) between two requesters, e.g. the integer issue slot and the address/branch-compare path. The block does four things:
- arbitrates round-robin with valid/ready handshakes,
- drives the shared ALU,
- registers each result into a per-port 1-entry response buffer,
- returns the result with the requester's tag.
It sits between the issue stage and the ALU and is the only driver of the ALU's inputs.

Parameters:
TAG_W, 4, width of the requester tag carried from request to response
NPORT, 2, number of requesters; fixed at 2, any other value is a configuration error

Ports:
clk  in  1  clock, all state on rising edge
resetn  in  1  asynchronous active-low reset
req_valid  in  2  per-port request valid
req_ready  out  2  per-port request accept
req_op0  in  12  port 0 one-hot ALU op (bit0 add … bit11 lui)
req_src1_0  in  32  port 0 operand 1
req_src2_0  in  32  port 0 operand 2
req_tag0  in  TAG_W  port 0 tag
req_op1  in  12  port 1 one-hot ALU op
req_src1_1  in  32  port 1 operand 1
req_src2_1  in  32  port 1 operand 2
req_tag1  in  TAG_W  port 1 tag
rsp_valid  out  2  per-port response valid
rsp_ready  in  2  per-port response accept
rsp_result0  out  32  port 0 result
rsp_tag0  out  TAG_W  port 0 tag
rsp_err0  out  1  port 0 illegal op (op not one-hot)
rsp_result1  out  32  port 1 result
rsp_tag1  out  TAG_W  port 1 tag
rsp_err1  out  1  port 1 illegal op

Behaviour:
- Reset (async, resetn=0):
  - rsp_valid=0, rsp_result*=0, rsp_tag*=0, rsp_err*=0.
  - Priority pointer prio=0, so port 0 wins the first tie.
  - req_ready=0 while resetn=0.
  - In-flight buffered responses are discarded.
  - Deassertion takes effect at the next clk edge.
- Eligibility: elig_i = ~rsp_valid[i] | rsp_ready[i]. This is a 1-entry buffer with same-cycle drain-and-refill.
- Grant (combinational):
  - req_ready[i] = elig_i & (~(req_valid[j] & elig_j) | prio==i), with j the other port.
  - req_ready[i] does not depend on req_valid[i].
  - At most one handshake (req_valid[i] & req_ready[i]) per cycle.
- ALU drive:
  - ALU inputs are muxed from the granted port.
  - With no handshake, the ALU inputs are driven to zero (op=0) to limit toggling.
- Capture: on a handshake for port i at edge N:
  - rsp_valid[i]=1, rsp_result_i=ALU result, rsp_tag_i=req_tag_i, rsp_err_i=(op not one-hot).
  - Latency is exactly 1 cycle: the response is visible in the cycle after acceptance.
- Illegal op (zero or multi-hot):
  - rsp_result_i=0 and rsp_err_i=1.
  - Still consumes a slot and advances the pointer.
- Drain: when rsp_valid[i]&rsp_ready[i] with no new capture, rsp_valid[i] clears at the edge. Result, tag and err hold their values.
- Pointer: after any handshake by port i, prio ← the other port. With no handshake, prio holds.
- Fairness: a continuously requesting, eligible port waits at most one grant to the other port.
- Back-pressure isolation: a stalled port (rsp_ready=0 with a full buffer) never blocks the other port.
- Stability: while rsp_valid[i]=1 and rsp_ready[i]=0, rsp_result_i, rsp_tag_i and rsp_err_i are held stable.
- Throughput:
  - 1 operation per cycle aggregate.
  - 1 per cycle per port if that port is the only requester and its consumer is always ready.

Decomposition:
- Shared package alu_pkg:
  - ALU_OP_W=12.
  - Op bit indices ALU_OP_ADD=0, SUB=1, SLT=2, SLTU=3, AND=4, NOR=5, OR=6, XOR=7, SLL=8, SRL=9, SRA=10, LUI=11.
- Sub-module alu_rr_arb2: two-way round-robin grant with eligibility inputs and a pointer register.
- The existing `alu` is instantiated once inside.

Test Plan:
- Port 0 only, op=12'h001, src1=0x00000005, src2=0x00000003, tag=3, rsp_ready=1 → next cycle rsp_valid=2'b01, rsp_result0=0x00000008, rsp_tag0=3, rsp_err0=0.
- Both ports valid every cycle, port 0 SUB 3-5, port 1 SLT 0xFFFFFFFF,1, rsp_ready=2'b11:
  - Grants alternate 0,1,0,1.
  - Port 0 results are 0xFFFFFFFE.
  - Port 1 results are 0x00000001.
  - SLTU on the same operands gives 0x00000000.
- Port 1 rsp_ready=0 after its first response, both ports requesting:
  - req_ready[1]=0 and rsp_result1 stays stable.
  - Port 0 receives a grant every cycle.
  - Raising rsp_ready[1] gives the same-cycle drain and refill.
- Port 0 op=12'h000, then op=12'h003 → rsp_err0=1 and rsp_result0=0 for both; pointer advances.
- Port 1 SRA op=12'h400, src1=0x80000000, src2=4 → 0xF8000000; SRL op=12'h200 → 0x08000000; LUI op=12'h800, src2=0xABCDE000 → 0xABCDE000.
- resetn pulsed low while both buffers are full → rsp_valid=0 and req_ready=0 immediately; after release, a tie goes to port 0 first.
